// File: rtl/hufftree_build_pkg.sv
// hufftree_build_pkg: shared FSM encoding and DEFLATE
// constants for the canonical Huffman LUT builder.
package hufftree_build_pkg;

  localparam int LEN_W = 4;
  localparam int DEFLATE_MAX_LEN = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_NEXTC = 3'd3,
    ST_ARD   = 3'd4,
    ST_ACHK  = 3'd5,
    ST_FILL  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/hufftree_build_bitrev.sv
// huff_bitrev: reverse the low len bits of code; upper
// result bits are zero. Ports: code, len in; rev out.
module huff_bitrev
  import hufftree_build_pkg::*;
#(
  parameter int MAX_CODE_LEN = 9
) (
  input  logic [MAX_CODE_LEN-1:0] code,
  input  logic [LEN_W-1:0]        len,
  output logic [MAX_CODE_LEN-1:0] rev
);

  logic [MAX_CODE_LEN-1:0] full;
  logic [LEN_W-1:0]        shamt;

  // Full-width reversal, then drop the bits that
  // came from above position len-1.
  always_comb begin
    full = '0;
    for (int i = 0; i < MAX_CODE_LEN; i++) begin
      full[i] = code[MAX_CODE_LEN-1-i];
    end
    shamt = LEN_W'(MAX_CODE_LEN) - len;
    rev   = full >> shamt;
  end

endmodule

// File: rtl/hufftree_build.sv
// hufftree_build: builds a bit-reversed canonical Huffman
// decode LUT from a code-length table read from a buffer.
// Ports: clk, rst_n, start, abort, num_syms, buff_addr_bias;
// len_rd_addr/len_rd_data length read; lut_wr_en/addr/data
// LUT write; busy, done, err_over, err_len, err_incomplete.
module hufftree_build
  import hufftree_build_pkg::*;
#(
  parameter int MAX_CODE_LEN = 9,
  parameter int SYM_W        = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SYM_W:0]           num_syms,
  output logic [SYM_W-1:0]         len_rd_addr,
  input  logic [SYM_W-1:0]         buff_addr_bias,
  input  logic [LEN_W-1:0]         len_rd_data,
  output logic                     lut_wr_en,
  output logic [MAX_CODE_LEN-1:0]  lut_wr_addr,
  output logic [LEN_W+SYM_W-1:0]   lut_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_over,
  output logic                     err_len,
  output logic                     err_incomplete
);

  localparam int KW = MAX_CODE_LEN;
  localparam int CW = MAX_CODE_LEN + 1;
  localparam int LW = MAX_CODE_LEN + 2;
  localparam int NW = SYM_W + 1;
  localparam int WW = LW + NW + 1;
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_CODE_LEN);

  state_t state_q, state_d;

  logic [SYM_W-1:0]    bias_q;
  logic [NW-1:0]       nsyms_q;
  logic [NW-1:0]       idx_q;
  logic [NW-1:0]       bl_count [16];
  logic [CW-1:0]       next_code [16];
  logic [CW-1:0]       code_q;
  logic signed [LW-1:0] left_q;
  logic [LEN_W-1:0]    l_q;
  logic [LEN_W-1:0]    len_q;
  logic [KW-1:0]       r_q;
  logic [KW-1:0]       k_q;

  logic                len_ok;
  logic                len_bad;
  logic                last_sym;
  logic [CW-1:0]       code_new;
  logic signed [WW-1:0] left_wide;
  logic                over_now;
  logic                left_pos;
  logic                nextc_last;
  logic [LEN_W-1:0]    fill_shamt;
  logic [CW-1:0]       one_sh;
  logic [KW-1:0]       k_max;
  logic                fill_last;
  logic [KW-1:0]       rev;

  huff_bitrev #(
    .MAX_CODE_LEN(MAX_CODE_LEN)
  ) u_bitrev (
    .code (next_code[len_rd_data][KW-1:0]),
    .len  (len_rd_data),
    .rev  (rev)
  );

  always_comb begin
    len_ok   = (len_rd_data != '0) &&
               (len_rd_data <= MAXL);
    len_bad  = (idx_q != '0) && (len_rd_data > MAXL);
    last_sym = (idx_q + NW'(1)) == nsyms_q;

    code_new = (code_q +
      CW'(bl_count[l_q - LEN_W'(1)])) << 1;

    // left is tracked wide so a huge bl_count can
    // never wrap a negative result back to positive.
    left_wide = $signed(
      {{(WW-LW-1){left_q[LW-1]}}, left_q, 1'b0})
      - $signed({{(WW-NW){1'b0}}, bl_count[l_q]});
    over_now   = left_wide[WW-1];
    left_pos   = !left_wide[WW-1] && (left_wide != '0);
    nextc_last = (l_q == MAXL);

    fill_shamt = MAXL - len_q;
    one_sh     = CW'(1) << fill_shamt;
    k_max      = KW'(one_sh - CW'(1));
    fill_last  = (k_q == k_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_COUNT;
      ST_COUNT: begin
        if (idx_q == nsyms_q) begin
          state_d = (err_len || len_bad) ?
                    ST_DONE : ST_NEXTC;
        end
      end
      ST_NEXTC: begin
        if (nextc_last) begin
          state_d = (err_over || over_now ||
                     nsyms_q == '0) ?
                    ST_DONE : ST_ARD;
        end
      end
      ST_ARD:   state_d = ST_ACHK;
      ST_ACHK: begin
        if (len_ok)        state_d = ST_FILL;
        else if (last_sym) state_d = ST_DONE;
        else               state_d = ST_ARD;
      end
      ST_FILL: begin
        if (fill_last) begin
          state_d = last_sym ? ST_DONE : ST_ARD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE) && !abort;
    lut_wr_en   = (state_q == ST_FILL) && !abort;
    len_rd_addr = bias_q + idx_q[SYM_W-1:0];
    lut_wr_addr = '0;
    lut_wr_data = '0;
    if (state_q == ST_FILL) begin
      lut_wr_addr = r_q | (k_q << len_q);
      lut_wr_data = {len_q, idx_q[SYM_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q         <= '0;
      nsyms_q        <= '0;
      idx_q          <= '0;
      code_q         <= '0;
      left_q         <= '0;
      l_q            <= '0;
      len_q          <= '0;
      r_q            <= '0;
      k_q            <= '0;
      err_over       <= 1'b0;
      err_len        <= 1'b0;
      err_incomplete <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        bl_count[i]  <= '0;
        next_code[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            bias_q  <= buff_addr_bias;
            nsyms_q <= num_syms;
          end
        end
        ST_CLEAR: begin
          for (int i = 0; i < 16; i++) begin
            bl_count[i] <= '0;
          end
          err_over       <= 1'b0;
          err_len        <= 1'b0;
          err_incomplete <= 1'b0;
          idx_q          <= '0;
          code_q         <= '0;
          left_q         <= LW'(1);
          l_q            <= LEN_W'(1);
        end
        ST_COUNT: begin
          // Data seen here belongs to symbol idx_q-1.
          if (idx_q != nsyms_q) idx_q <= idx_q + NW'(1);
          else                  idx_q <= '0;
          if (idx_q != '0) begin
            if (len_rd_data > MAXL) begin
              err_len <= 1'b1;
            end else if (len_rd_data != '0) begin
              bl_count[len_rd_data] <=
                bl_count[len_rd_data] + NW'(1);
            end
          end
        end
        ST_NEXTC: begin
          next_code[l_q] <= code_new;
          code_q         <= code_new;
          left_q         <= left_wide[LW-1:0];
          l_q            <= l_q + LEN_W'(1);
          if (over_now) err_over <= 1'b1;
          if (nextc_last && !err_over &&
              !over_now && left_pos) begin
            err_incomplete <= 1'b1;
          end
        end
        ST_ACHK: begin
          if (len_ok) begin
            next_code[len_rd_data] <=
              next_code[len_rd_data] + CW'(1);
            r_q   <= rev;
            len_q <= len_rd_data;
            k_q   <= '0;
          end else begin
            idx_q <= idx_q + NW'(1);
          end
        end
        ST_FILL: begin
          k_q <= k_q + KW'(1);
          if (fill_last) idx_q <= idx_q + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
